// File: rtl/free_play_engine.sv
// Free-play mode: debounced note keys and octave buttons drive a priority-selected
// square-wave tone with octave shift and an optional sustain tail.

module free_play_debounce #(
  parameter int W = 1,
  parameter int D = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] raw_i,
  output logic [W-1:0] db_o
);
  localparam int CW = $clog2(D);

  logic [W-1:0]  s1_q, s2_q, prev_q, db_q, db_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          diff;

  always_comb begin
    // NOTE: every comb output gets a default first so no path can infer a latch.
    cnt_d = cnt_q;
    db_d  = db_q;
    diff  = (s2_q != prev_q);
    if (diff)                        cnt_d = '0;
    else if (cnt_q != CW'(D - 1))    cnt_d = cnt_q + CW'(1);
    // Commit on the cycle the stable count reaches D-1.
    if (!diff && cnt_q == CW'(D - 2)) db_d = s2_q;
  end

  // NOTE: all state uses non-blocking so each register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q   <= '0;
      s2_q   <= '0;
      prev_q <= '0;
      db_q   <= '0;
      cnt_q  <= '0;
    end else begin
      s1_q   <= raw_i;
      s2_q   <= s1_q;
      prev_q <= s2_q;
      db_q   <= db_d;
      cnt_q  <= cnt_d;
    end
  end

  assign db_o = db_q;
endmodule

module free_play_engine #(
  parameter int CLK_HZ       = 100_000_000,
  parameter int NUM_KEYS     = 8,
  parameter int OCT_LEVELS   = 3,
  parameter int OCT_DEFAULT  = 1,
  parameter int DEBOUNCE_CYC = 2_000_000,
  parameter int SUSTAIN_CYC  = 25_000_000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_KEYS-1:0] keys,
  input  logic                oct_up,
  input  logic                oct_down,
  input  logic                sustain_en,
  output logic                buzzer,
  output logic [3:0]          note_idx,
  output logic [1:0]          octave,
  output logic [NUM_KEYS-1:0] led,
  output logic                playing
);
  localparam int         TW      = $clog2(CLK_HZ / 523 + 1);
  localparam int         SW      = $clog2(SUSTAIN_CYC + 1);
  localparam logic [1:0] OCT_MAX = 2'(OCT_LEVELS - 1);

  function automatic logic [TW-1:0] calc_half(input int i);
    logic [63:0] f_mhz;
    case (i)
      0:       f_mhz = 64'd261626;
      1:       f_mhz = 64'd293665;
      2:       f_mhz = 64'd329628;
      3:       f_mhz = 64'd349228;
      4:       f_mhz = 64'd391995;
      5:       f_mhz = 64'd440000;
      6:       f_mhz = 64'd493883;
      default: f_mhz = 64'd523251;
    endcase
    return TW'((64'(CLK_HZ) * 64'd1000) / (64'd2 * f_mhz));
  endfunction

  localparam logic [TW-1:0] BASE_HALF [8] = '{
    calc_half(0), calc_half(1), calc_half(2), calc_half(3),
    calc_half(4), calc_half(5), calc_half(6), calc_half(7)
  };

  typedef enum logic [1:0] {S_IDLE, S_PLAY, S_SUSTAIN} state_t;

  logic [NUM_KEYS-1:0] key_db;
  logic [1:0]          btn_db, btn_prev_q;
  state_t              state_q, state_d;
  logic [2:0]          note_q, key_sel;
  logic                key_hit, restart, up_p, dn_p, tone_wrap;
  logic [TW-1:0]       tone_cnt_q, half;
  logic [SW-1:0]       sus_cnt_q;
  logic [1:0]          octave_q;
  logic                buzzer_q, playing_q;
  logic [3:0]          note_idx_q;
  logic [NUM_KEYS-1:0] led_q;

  free_play_debounce #(.W(NUM_KEYS), .D(DEBOUNCE_CYC)) u_key_db (
    .clk(clk), .rst(rst), .raw_i(keys), .db_o(key_db)
  );

  free_play_debounce #(.W(2), .D(DEBOUNCE_CYC)) u_btn_db (
    .clk(clk), .rst(rst), .raw_i({oct_up, oct_down}), .db_o(btn_db)
  );

  assign up_p = btn_db[1] & ~btn_prev_q[1];
  assign dn_p = btn_db[0] & ~btn_prev_q[0];

  always_comb begin
    key_hit = 1'b0;
    key_sel = '0;
    // Descending scan so the lowest set index is the last to win.
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (key_db[i]) begin
        key_hit = 1'b1;
        key_sel = 3'(i);
      end
    end
  end

  assign half      = BASE_HALF[note_q] >> octave_q;
  assign tone_wrap = (tone_cnt_q >= half - TW'(1));
  assign restart   = key_hit && (state_q != S_PLAY || key_sel != note_q);

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (key_hit) state_d = S_PLAY;
      S_PLAY:    if (!key_hit) state_d = sustain_en ? S_SUSTAIN : S_IDLE;
      S_SUSTAIN: begin
        if (key_hit)                             state_d = S_PLAY;
        else if (!sustain_en || sus_cnt_q == '0) state_d = S_IDLE;
      end
      default:   state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      btn_prev_q <= '0;
      octave_q   <= 2'(OCT_DEFAULT);
      note_q     <= '0;
      tone_cnt_q <= '0;
      sus_cnt_q  <= '0;
      buzzer_q   <= 1'b0;
      note_idx_q <= '0;
      led_q      <= '0;
      playing_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      btn_prev_q <= btn_db;
      if (up_p && !dn_p && octave_q != OCT_MAX)    octave_q <= octave_q + 2'd1;
      else if (dn_p && !up_p && octave_q != 2'd0)  octave_q <= octave_q - 2'd1;

      if (state_q == S_PLAY && state_d == S_SUSTAIN) sus_cnt_q <= SW'(SUSTAIN_CYC - 1);
      else if (state_q == S_SUSTAIN && sus_cnt_q != '0) sus_cnt_q <= sus_cnt_q - SW'(1);

      if (state_d == S_IDLE) begin
        tone_cnt_q <= '0;
        buzzer_q   <= 1'b0;
        note_idx_q <= '0;
        led_q      <= '0;
        playing_q  <= 1'b0;
      end else if (restart) begin
        note_q     <= key_sel;
        tone_cnt_q <= '0;
        buzzer_q   <= 1'b0;
        note_idx_q <= 4'(key_sel) + 4'd1;
        led_q      <= NUM_KEYS'(1) << key_sel;
        playing_q  <= 1'b1;
      end else if (tone_wrap) begin
        tone_cnt_q <= '0;
        buzzer_q   <= ~buzzer_q;
      end else begin
        tone_cnt_q <= tone_cnt_q + TW'(1);
      end
    end
  end

  assign buzzer   = buzzer_q;
  assign note_idx = note_idx_q;
  assign octave   = octave_q;
  assign led      = led_q;
  assign playing  = playing_q;
endmodule

// File: tb/tb_free_play_engine.sv
// Directed bench for free_play_engine with small clock/debounce/sustain values
// so every latency and tone period can be checked cycle-exactly.

module tb_free_play_engine;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] keys = '0;
  logic       oct_up = 1'b0;
  logic       oct_down = 1'b0;
  logic       sustain_en = 1'b0;
  logic       buzzer;
  logic [3:0] note_idx;
  logic [1:0] octave;
  logic [7:0] led;
  logic       playing;

  int n_cmp = 0;
  int n_bad = 0;

  free_play_engine #(
    .CLK_HZ(1_000_000), .NUM_KEYS(8), .OCT_LEVELS(3), .OCT_DEFAULT(1),
    .DEBOUNCE_CYC(4), .SUSTAIN_CYC(100)
  ) dut (
    .clk(clk), .rst(rst), .keys(keys), .oct_up(oct_up), .oct_down(oct_down),
    .sustain_en(sustain_en), .buzzer(buzzer), .note_idx(note_idx),
    .octave(octave), .led(led), .playing(playing)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic press(input logic up, input logic down);
    oct_up = up;
    oct_down = down;
    step(10);
    oct_up = 1'b0;
    oct_down = 1'b0;
    step(10);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not reach the end of the sequence");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    step(3);
    chk("rst_buzzer", buzzer, 0);
    chk("rst_note", note_idx, 0);
    chk("rst_led", led, 0);
    chk("rst_playing", playing, 0);
    chk("rst_octave", octave, 1);
    rst = 1'b0;
    step(10);

    // Chatter: 3-cycle key pulse is rejected
    keys = 8'h01;
    step(3);
    keys = 8'h00;
    step(15);
    chk("chatter_note", note_idx, 0);
    chk("chatter_playing", playing, 0);
    chk("chatter_buzzer", buzzer, 0);

    // Key 0 at octave 1: half 955
    keys = 8'h01;
    step(6);
    chk("t1_before_note", note_idx, 0);
    step(1);
    chk("t1_note", note_idx, 1);
    chk("t1_led", led, 8'h01);
    chk("t1_playing", playing, 1);
    chk("t1_buzzer0", buzzer, 0);
    step(954);
    chk("t1_pre_toggle", buzzer, 0);
    step(1);
    chk("t1_toggle", buzzer, 1);
    step(954);
    chk("t1_pre_toggle2", buzzer, 1);
    step(1);
    chk("t1_toggle2", buzzer, 0);

    // Lowest index wins: E4 half 1516>>1 = 758
    keys = 8'h24;
    step(6);
    chk("t2_before_note", note_idx, 1);
    step(1);
    chk("t2_note_e4", note_idx, 3);
    chk("t2_led_e4", led, 8'h04);
    chk("t2_buzzer_e4", buzzer, 0);
    step(757);
    chk("t2_e4_pre", buzzer, 0);
    step(1);
    chk("t2_e4_toggle", buzzer, 1);

    // A4 restart: half 1136>>1 = 568
    keys = 8'h20;
    step(7);
    chk("t2_note_a4", note_idx, 6);
    chk("t2_led_a4", led, 8'h20);
    chk("t2_buzzer_restart", buzzer, 0);
    step(567);
    chk("t2_a4_pre", buzzer, 0);
    step(1);
    chk("t2_a4_toggle", buzzer, 1);

    // Sustain tail of 100 cycles
    sustain_en = 1'b1;
    keys = 8'h00;
    step(7);
    chk("t5_sus_playing", playing, 1);
    chk("t5_sus_led", led, 8'h20);
    chk("t5_sus_note", note_idx, 6);
    step(99);
    chk("t5_sus_end_playing", playing, 1);
    chk("t5_sus_end_led", led, 8'h20);
    step(1);
    chk("t5_idle_playing", playing, 0);
    chk("t5_idle_led", led, 0);
    chk("t5_idle_note", note_idx, 0);
    chk("t5_idle_buzzer", buzzer, 0);

    // No sustain: IDLE right after debounced release
    sustain_en = 1'b0;
    keys = 8'h20;
    step(7);
    chk("t5b_playing", playing, 1);
    keys = 8'h00;
    step(6);
    chk("t5b_hold", playing, 1);
    step(1);
    chk("t5b_idle", playing, 0);

    // Octave buttons
    oct_up = 1'b1;
    step(6);
    chk("t4_up_before", octave, 1);
    step(1);
    chk("t4_up", octave, 2);
    step(3);
    oct_up = 1'b0;
    step(10);
    press(1'b1, 1'b0);
    chk("t4_up_sat", octave, 2);
    press(1'b0, 1'b1);
    chk("t4_down1", octave, 1);
    press(1'b1, 1'b1);
    chk("t4_both", octave, 1);
    press(1'b0, 1'b1);
    chk("t4_down2", octave, 0);
    press(1'b0, 1'b1);
    chk("t4_down_sat", octave, 0);

    // Key 0 at octave 0: half 1911
    keys = 8'h01;
    step(7);
    chk("t4_oct0_note", note_idx, 1);
    step(1910);
    chk("t4_oct0_pre", buzzer, 0);
    step(1);
    chk("t4_oct0_toggle", buzzer, 1);

    // Reset in SUSTAIN, key held through reset
    sustain_en = 1'b1;
    keys = 8'h00;
    step(7);
    chk("t6_in_sustain", playing, 1);
    step(20);
    rst = 1'b1;
    keys = 8'h01;
    step(1);
    chk("t6_rst_buzzer", buzzer, 0);
    chk("t6_rst_note", note_idx, 0);
    chk("t6_rst_led", led, 0);
    chk("t6_rst_playing", playing, 0);
    chk("t6_rst_octave", octave, 1);
    rst = 1'b0;
    n = 0;
    while (!playing && n < 8) begin
      step(1);
      n++;
    end
    chk("t6_replay_playing", playing, 1);
    chk("t6_replay_latency", n, 7);
    chk("t6_replay_note", note_idx, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
